fix_add_arbiter: RTL and testbench

Shares one pipelined fixed-point adder (`FixAdd`, registered, ADD_LAT cycles) among NUM_REQ requesters in the CNN datapath, for example per-channel partial-sum accumulators. Arbitration is round-robin with a valid/ready handshake. The block tracks each in-flight operation's owner through a tag pipeline and returns the sum as a one-hot-tagged strobe. Overflow is detected on every result. Saturation is optional.

---
 rtl/fix_add_arbiter.sv | 126 ++++++++++++
 tb/tb_fix_add_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fix_add_arbiter.sv
// Round-robin arbiter sharing one registered fixed-point adder among NUM_REQ requesters.
// Optional saturation of overflowed results is enabled by defining FIX_ADD_SAT_EN.
module fix_add_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]         add_a_o,
    output logic [WIDTH-1:0]         add_b_o,
    input  logic [WIDTH-1:0]         add_s_i,
    output logic [NUM_REQ-1:0]       res_valid_o,
    output logic [WIDTH-1:0]         res_sum_o,
    output logic                     res_ovf_o,
    output logic                     busy_o
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int IDX_W = PTR_W + 1;
    localparam int DEPTH = ADD_LAT + 1;

    typedef struct packed {
        logic               vld;
        logic [NUM_REQ-1:0] id;
        logic               sa;
        logic               sb;
    } tag_t;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   add_a_q, add_b_q;
    logic [NUM_REQ-1:0] res_valid_q;
    logic [WIDTH-1:0]   res_sum_q, res_sum_d;
    logic               res_ovf_q, res_ovf_d;
    tag_t               tag_q [DEPTH];
    tag_t               tag_d, tail;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               found;
    logic [IDX_W-1:0]   cand;
    logic               hs;
    logic [WIDTH-1:0]   op_a, op_b;

    // First valid requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + IDX_W'(k);
            if (cand >= IDX_W'(NUM_REQ)) cand = cand - IDX_W'(NUM_REQ);
            if (!found && req_valid_i[cand[PTR_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    assign req_ready_o = (en_i && !rst_i) ? grant : '0;
    assign hs          = |req_ready_o;
    assign op_a        = req_a_i[grant_idx*WIDTH +: WIDTH];
    assign op_b        = req_b_i[grant_idx*WIDTH +: WIDTH];
    assign ptr_d       = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        tag_d.vld = hs;
        tag_d.id  = req_ready_o;
        tag_d.sa  = op_a[WIDTH-1];
        tag_d.sb  = op_b[WIDTH-1];
    end

    assign tail = tag_q[DEPTH-1];

    always_comb begin
        res_ovf_d = tail.vld && (tail.sa == tail.sb) && (add_s_i[WIDTH-1] != tail.sa);
`ifdef FIX_ADD_SAT_EN
        if (res_ovf_d)
            res_sum_d = tail.sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            res_sum_d = add_s_i;
`else
        res_sum_d = add_s_i;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            res_valid_q <= '0;
            res_sum_q   <= '0;
            res_ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            if (hs) begin
                ptr_q   <= ptr_d;
                add_a_q <= op_a;
                add_b_q <= op_b;
            end
            tag_q[0] <= tag_d;
            for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
            res_valid_q <= tail.vld ? tail.id : '0;
            res_ovf_q   <= res_ovf_d;
            if (tail.vld) res_sum_q <= res_sum_d;
        end
    end

    always_comb begin
        busy_o = |res_valid_q;
        for (int i = 0; i < DEPTH; i++) busy_o = busy_o | tag_q[i].vld;
    end

    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign res_valid_o = res_valid_q;
    assign res_sum_o   = res_sum_q;
    assign res_ovf_o   = res_ovf_q;
endmodule

// File: tb/tb_fix_add_arbiter.sv
// Self-checking bench for fix_add_arbiter: directed steps plus random traffic against a queue model.
module tb_fix_add_arbiter;
    localparam int W = 16;
    localparam int N = 4;
    localparam int L = 1;
    localparam int SMAX = 2**(W-1) - 1;
    localparam int SMIN = -(2**(W-1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, en;
    logic [N-1:0]   rv;
    logic [N*W-1:0] ra, rb;
    logic [N-1:0]   ready, res_valid;
    logic [W-1:0]   add_a, add_b, add_s, res_sum;
    logic           res_ovf, busy;

    fix_add_arbiter #(.WIDTH(W), .NUM_REQ(N), .ADD_LAT(L)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_valid_i(rv), .req_a_i(ra), .req_b_i(rb),
        .req_ready_o(ready), .add_a_o(add_a), .add_b_o(add_b), .add_s_i(add_s),
        .res_valid_o(res_valid), .res_sum_o(res_sum), .res_ovf_o(res_ovf), .busy_o(busy)
    );

    // External adder: registered, L cycles, never reset.
    logic [W-1:0] spipe [L];
    always @(posedge clk) begin
        spipe[0] <= add_a + add_b;
        for (int i = 1; i < L; i++) spipe[i] <= spipe[i-1];
    end
    assign add_s = spipe[L-1];

    typedef struct {
        int           due;
        logic [N-1:0] id;
        logic [W-1:0] sum;
        logic         ovf;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0, total = 0, bad = 0, mptr = 0;
    logic         started = 1'b0;
    logic [W-1:0] m_add_a = '0, m_add_b = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] sum, output logic ovf);
        int s;
        s   = int'($signed(a)) + int'($signed(b));
        ovf = (s > SMAX) || (s < SMIN);
`ifdef FIX_ADD_SAT_EN
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
`endif
        sum = s[W-1:0];
    endtask

    // One clock cycle: check everything mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic [N-1:0] eg;
        int           gi, idx;
        exp_t         e;
        #1;
        eg = '0;
        gi = -1;
        if (en && !rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (gi < 0 && rv[idx]) gi = idx;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("req_ready", 32'(ready), 32'(eg));
        if (started) begin
            chk("busy", 32'(busy), 32'(q.size() > 0));
            chk("add_a", 32'(add_a), 32'(m_add_a));
            chk("add_b", 32'(add_b), 32'(m_add_b));
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("res_valid", 32'(res_valid), 32'(e.id));
                chk("res_sum", 32'(res_sum), 32'(e.sum));
                chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
            end else begin
                chk("res_valid_idle", 32'(res_valid), 32'(0));
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            mptr    = 0;
            m_add_a = '0;
            m_add_b = '0;
            started = 1'b1;
        end else if (gi >= 0) begin
            e.due   = cyc + 2 + L;
            e.id    = eg;
            m_add_a = ra[gi*W +: W];
            m_add_b = rb[gi*W +: W];
            ref_add(m_add_a, m_add_b, e.sum, e.ovf);
            q.push_back(e);
            mptr = (gi + 1) % N;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rv = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic one_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        rv = '0;
        rv[r] = 1'b1;
        ra[r*W +: W] = a;
        rb[r*W +: W] = b;
        cycle();
        rv = '0;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_res_sum"}, 32'(res_sum), 32'(0));
        chk({tag, "_res_ovf"}, 32'(res_ovf), 32'(0));
        chk({tag, "_add_a"}, 32'(add_a), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; rv = '1;
        for (int i = 0; i < N; i++) begin
            ra[i*W +: W] = W'(16'h0010 * (i + 1));
            rb[i*W +: W] = W'(16'h0001 * (i + 1));
        end
        // Reset held with all requesters valid
        for (int i = 0; i < 3; i++) cycle();
        chk_reset_outputs("reset");
        rst = 1'b0;
        // Fairness: all valid for 8 cycles, then drain
        for (int i = 0; i < 8; i++) cycle();
        idle(5);
        // Single op from requester 2
        rst = 1'b1; cycle(); rst = 1'b0;
        one_op(2, 16'h0100, 16'h0200);
        idle(5);
        // Overflow cases and in-range boundaries
        one_op(0, 16'h7000, 16'h2000);
        one_op(1, 16'h8000, 16'hFFFF);
        one_op(2, 16'h8000, 16'h8000);
        one_op(3, 16'h7FFF, 16'h0001);
        one_op(0, 16'h7FFF, 16'h8000);
        one_op(1, 16'hC000, 16'hC000);
        idle(5);
        // Reset mid-flight
        one_op(1, 16'h1111, 16'h2222);
        one_op(2, 16'h3333, 16'h4444);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk_reset_outputs("midrst");
        idle(4);
        // en gating with requesters 1 and 3
        rv = 4'b1010;
        cycle();
        en = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        en = 1'b1;
        cycle();
        idle(5);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rv  = N'($urandom_range(0, 2**N - 1));
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 59) == 0);
            for (int r = 0; r < N; r++) begin
                case ($urandom_range(0, 3))
                    0:       ra[r*W +: W] = 16'h7FF0 + W'($urandom_range(0, 15));
                    1:       ra[r*W +: W] = 16'h8000 + W'($urandom_range(0, 15));
                    default: ra[r*W +: W] = W'($urandom);
                endcase
                rb[r*W +: W] = W'($urandom);
            end
            cycle();
        end
        rst = 1'b0; en = 1'b1;
        idle(6);
        chk("final_queue_empty", 32'(q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
